// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers for the read and write controllers.
// Build option FIFO_FWFT_EN selects first-word-fall-through reads.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] fifo_data_t;
  typedef logic [ADDR_W_DEF:0]   fifo_ptr_t;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_t;

  // Wrap-bit pointers make plain subtraction the occupancy.
  function automatic fifo_ptr_t ptr_occ(
    input fifo_ptr_t wr,
    input fifo_ptr_t rd
  );
    return wr - rd;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer feeding the consumer in FIFO_FWFT_EN builds.
// Arriving data bypasses straight to the output while the buffer is empty.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arr_valid,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    unique case (state_q)
      SK_EMPTY: begin
        if (arr_valid && !pop) begin
          state_d = SK_ONE;
          e0_d    = arr_data;
        end
      end
      SK_ONE: begin
        if (arr_valid && !pop) begin
          state_d = SK_TWO;
          e1_d    = arr_data;
        end else if (arr_valid && pop) begin
          e0_d = arr_data;
        end else if (pop) begin
          state_d = SK_EMPTY;
        end
      end
      SK_TWO: begin
        if (pop) begin
          e0_d = e1_q;
          if (arr_valid) e1_d = arr_data;
          else state_d = SK_ONE;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != SK_EMPTY) | arr_valid;
    out_data  = e0_q;
    occ       = 2'd0;
    if (state_q == SK_EMPTY)
      out_data = arr_valid ? arr_data : '0;
    if (state_q == SK_ONE) occ = 2'd1;
    if (state_q == SK_TWO) occ = 2'd2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SK_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: read pointer, empty flags, storage read port.
// Define FIFO_FWFT_EN for first-word-fall-through via fifo_rd_skid.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              renb,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              empty,
  output logic              almost_empty,
  output logic              underflow
);

  typedef logic [ADDR_W+1:0] occ_t;
  localparam occ_t AE_T = occ_t'(AE_THRESH);

  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] occ_mem;
  logic            underflow_q, underflow_d;
  occ_t            occ_all;

  assign occ_mem      = wr_ptr - rd_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign mem_raddr    = rd_ptr_q[ADDR_W-1:0];
  assign underflow    = underflow_q;
  assign almost_empty = reset | (occ_all <= AE_T);

`ifdef FIFO_FWFT_EN

  logic              arr_q, arr_d;
  logic [1:0]        infl_q, infl_d;
  logic              pop;
  logic              sk_valid;
  logic [DATA_W-1:0] sk_data;
  logic [1:0]        sk_occ;
  logic [2:0]        demand;

  fifo_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .arr_valid (arr_q),
    .arr_data  (mem_rdata),
    .pop       (pop),
    .out_valid (sk_valid),
    .out_data  (sk_data),
    .occ       (sk_occ)
  );

  // Prefetch only while buffered plus outstanding words stay below two.
  always_comb begin
    pop         = renb & sk_valid;
    demand      = {1'b0, sk_occ} + {1'b0, infl_q} - {2'b0, pop};
    mem_ren     = ~reset & (occ_mem != '0) & (demand < 3'd2);
    arr_d       = mem_ren;
    infl_d      = infl_q + {1'b0, mem_ren} - {1'b0, arr_q};
    rd_ptr_d    = rd_ptr_q + {{ADDR_W{1'b0}}, mem_ren};
    underflow_d = renb & ~sk_valid;
    occ_all     = {1'b0, occ_mem} + occ_t'(sk_occ) + occ_t'(infl_q);
  end

  assign dvalid = sk_valid;
  assign dout   = sk_data;
  assign empty  = ~sk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      arr_q       <= 1'b0;
      infl_q      <= 2'd0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      arr_q       <= arr_d;
      infl_q      <= infl_d;
      underflow_q <= underflow_d;
    end
  end

`else

  logic dvalid_q, dvalid_d;

  always_comb begin
    empty       = reset | (rd_ptr_q == wr_ptr);
    mem_ren     = renb & ~empty;
    rd_ptr_d    = rd_ptr_q + {{ADDR_W{1'b0}}, mem_ren};
    dvalid_d    = mem_ren;
    underflow_d = renb & empty;
    occ_all     = {1'b0, occ_mem};
  end

  assign dvalid = dvalid_q;
  assign dout   = dvalid_q ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      dvalid_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      dvalid_q    <= dvalid_d;
      underflow_q <= underflow_d;
    end
  end

`endif

endmodule
